// File: rtl/wm_embed_stream_if.sv
// Pixel/key stream bundle for wm_embed_stream; master drives the stream, slave is the block.
interface wm_embed_stream_if #(
  parameter int PIX_W = 8,
  parameter int KW    = 32
);
  logic             wm_load;
  logic [KW-1:0]    wm_key;
  logic             mode;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_out;
  logic             out_valid;
  logic             out_ready;
  logic             wm_wrap;
  logic [KW-1:0]    wm_out;
  logic             wm_out_valid;

  modport master (
    output wm_load, wm_key, mode, pix_in, pix_valid, out_ready,
    input  pix_ready, pix_out, out_valid, wm_wrap, wm_out, wm_out_valid
  );

  modport slave (
    input  wm_load, wm_key, mode, pix_in, pix_valid, out_ready,
    output pix_ready, pix_out, out_valid, wm_wrap, wm_out, wm_out_valid
  );
endinterface

// File: rtl/wm_embed_stream.sv
// LSB watermark embedder on a 1-deep registered pixel stream.
// Define WM_EXTRACT_EN to build the extract (key recovery) path.
module wm_embed_stream #(
  parameter int PIX_W = 8,
  parameter int NCH   = 4,
  parameter int K     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  wm_embed_stream_if.slave   bus
);
  localparam int KW    = NCH * PIX_W;
  localparam int NPTR  = KW / K;
  localparam int PTR_W = (NPTR > 1) ? $clog2(NPTR) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NPTR - 1);
  localparam logic [PIX_W-1:0] LOW_MASK = ~({PIX_W{1'b1}} << K);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    key;
  logic [PTR_W-1:0] ptr, ptr_eff;
  logic             last_mode, mode_eff;
  logic             accept, wrap;
  logic [K-1:0]     key_bits;
  logic [PIX_W-1:0] pix_nxt;

`ifdef WM_EXTRACT_EN
  assign mode_eff = bus.mode;
`else
  assign mode_eff = 1'b0;
  wire unused_mode = bus.mode;
`endif

  always_comb begin
    state_nxt = state;
    if (state == IDLE && bus.wm_load) state_nxt = RUN;
    bus.pix_ready = (state == RUN || mode_eff) && !bus.wm_load &&
                    (!bus.out_valid || bus.out_ready);
    accept   = bus.pix_valid && bus.pix_ready;
    // A mode switch restarts the bit walk from bit 0
    ptr_eff  = (mode_eff != last_mode) ? '0 : ptr;
    wrap     = (ptr_eff == PTR_LAST);
    key_bits = key[ptr_eff*K +: K];
    pix_nxt  = mode_eff ? bus.pix_in
                        : ((bus.pix_in & ~LOW_MASK) | PIX_W'(key_bits));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      key           <= '0;
      ptr           <= '0;
      last_mode     <= 1'b0;
      bus.pix_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.wm_wrap   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus.wm_wrap <= accept && wrap;
      if (bus.wm_load) begin
        key <= bus.wm_key;
        ptr <= '0;
      end else if (accept) begin
        ptr <= wrap ? '0 : ptr_eff + 1'b1;
      end
      if (accept) begin
        last_mode     <= mode_eff;
        bus.pix_out   <= pix_nxt;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef WM_EXTRACT_EN
  logic [KW-1:0] collect, collect_nxt;

  always_comb begin
    collect_nxt = (mode_eff != last_mode) ? '0 : collect;
    collect_nxt[ptr_eff*K +: K] = bus.pix_in[K-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collect          <= '0;
      bus.wm_out       <= '0;
      bus.wm_out_valid <= 1'b0;
    end else begin
      bus.wm_out_valid <= 1'b0;
      if (accept && mode_eff) begin
        collect <= collect_nxt;
        if (wrap) begin
          bus.wm_out       <= collect_nxt;
          bus.wm_out_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign bus.wm_out       = '0;
  assign bus.wm_out_valid = 1'b0;
`endif
endmodule

// File: tb/tb_wm_embed_stream.sv
// Directed bench for wm_embed_stream (defaults PIX_W=8, NCH=4, K=1).
module tb_wm_embed_stream;
  localparam int PIX_W = 8;
  localparam int NCH   = 4;
  localparam int K     = 1;
  localparam int KW    = NCH * PIX_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wm_embed_stream_if #(.PIX_W(PIX_W), .KW(KW)) bus();
  wm_embed_stream #(.PIX_W(PIX_W), .NCH(NCH), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [KW-1:0] mkey;
  int            mptr;

  function automatic logic [7:0] emb(input logic [7:0] p, input logic [31:0] k, input int ptr);
    return {p[7:1], k[ptr]};
  endfunction

  task automatic load_key(input logic [31:0] k);
    bus.wm_load = 1'b1; bus.wm_key = k;
    @(negedge clk);
    bus.wm_load = 1'b0;
    mkey = k; mptr = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.pix_out !== 8'h00) begin bad++; $display("FAIL rst_pix_out got=%h exp=00", bus.pix_out); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.wm_wrap !== 1'b0) begin bad++; $display("FAIL rst_wm_wrap got=%b exp=0", bus.wm_wrap); end
    total++; if (bus.wm_out !== 32'h0) begin bad++; $display("FAIL rst_wm_out got=%h exp=0", bus.wm_out); end
    total++; if (bus.wm_out_valid !== 1'b0) begin bad++; $display("FAIL rst_wm_out_valid got=%b exp=0", bus.wm_out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_no_key;
    bus.mode = 1'b0; bus.pix_valid = 1'b1; bus.pix_in = 8'h55;
    repeat (4) begin
      #1;
      total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL nokey_ready got=%b exp=0", bus.pix_ready); end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL nokey_out_valid got=%b exp=0", bus.out_valid); end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_embed;
    int wraps = 0;
    logic [7:0] p0, p7;
    p0 = '0; p7 = '0;
    load_key(32'h02208880);
    bus.pix_valid = 1'b1; bus.pix_in = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++; if (bus.pix_ready !== 1'b1) begin bad++; $display("FAIL emb_ready[%0d] got=%b exp=1", i, bus.pix_ready); end
      @(negedge clk);
      if (i == 0) p0 = bus.pix_out;
      if (i == 7) p7 = bus.pix_out;
      if (bus.wm_wrap === 1'b1) wraps++;
      total++; if (bus.pix_out !== emb(8'hFF, mkey, i)) begin bad++; $display("FAIL emb_pix[%0d] got=%h exp=%h", i, bus.pix_out, emb(8'hFF, mkey, i)); end
      total++; if (bus.wm_wrap !== (i == 31)) begin bad++; $display("FAIL emb_wrap[%0d] got=%b exp=%b", i, bus.wm_wrap, (i == 31)); end
    end
    mptr = 0;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    total++; if (p0 !== 8'hFE) begin bad++; $display("FAIL emb_pixel0 got=%h exp=FE", p0); end
    total++; if (p7 !== 8'hFF) begin bad++; $display("FAIL emb_pixel7 got=%h exp=FF", p7); end
    total++; if (wraps != 1) begin bad++; $display("FAIL emb_wrap_count got=%0d exp=1", wraps); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL emb_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    logic [7:0] ea, eb;
    bus.out_ready = 1'b1; bus.pix_valid = 1'b1; bus.pix_in = 8'h35;
    ea = emb(8'h35, mkey, mptr);
    @(negedge clk);
    mptr++;
    total++; if (bus.pix_out !== ea) begin bad++; $display("FAIL bp_first got=%h exp=%h", bus.pix_out, ea); end
    bus.out_ready = 1'b0; bus.pix_in = 8'h5B;
    #1;
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_stall got=%b exp=0", bus.pix_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.pix_out !== ea) begin bad++; $display("FAIL bp_hold[%0d] got=%h exp=%h", c, bus.pix_out, ea); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, bus.out_valid); end
      total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, bus.pix_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.pix_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", bus.pix_ready); end
    eb = emb(8'h5B, mkey, mptr);
    @(negedge clk);
    mptr++;
    total++; if (bus.pix_out !== eb) begin bad++; $display("FAIL bp_second got=%h exp=%h", bus.pix_out, eb); end
    bus.pix_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_load_midstream;
    logic [7:0] pin;
    load_key(32'h02208880);
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pin = 8'(i * 29 + 3);
      bus.pix_in = pin;
      @(negedge clk);
      total++; if (bus.pix_out !== emb(pin, mkey, i)) begin bad++; $display("FAIL ld_pre[%0d] got=%h exp=%h", i, bus.pix_out, emb(pin, mkey, i)); end
    end
    bus.wm_load = 1'b1; bus.wm_key = 32'h03300CC0; bus.pix_in = 8'hFF;
    #1;
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL ld_block got=%b exp=0", bus.pix_ready); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ld_no_accept got=%b exp=0", bus.out_valid); end
    bus.wm_load = 1'b0; mkey = 32'h03300CC0; mptr = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) begin
        total++; if (bus.pix_out[0] !== 1'b0) begin bad++; $display("FAIL ld_first_lsb got=%b exp=0", bus.pix_out[0]); end
      end
      total++; if (bus.pix_out !== emb(8'hFF, mkey, j)) begin bad++; $display("FAIL ld_post[%0d] got=%h exp=%h", j, bus.pix_out, emb(8'hFF, mkey, j)); end
    end
    mptr = 8;
    bus.pix_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef WM_EXTRACT_EN
  task automatic test_extract;
    logic [31:0] ek;
    logic [7:0]  pin;
    logic [6:0]  hi;
    int pulses = 0;
    ek = 32'hAA6B726A;
    bus.mode = 1'b1; bus.pix_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      hi = 7'(i * 5 + 1);
      pin = {hi, ek[i]};
      bus.pix_in = pin;
      @(negedge clk);
      if (bus.wm_out_valid === 1'b1) pulses++;
      total++; if (bus.pix_out !== pin) begin bad++; $display("FAIL ext_pass[%0d] got=%h exp=%h", i, bus.pix_out, pin); end
      total++; if (bus.wm_out_valid !== (i == 31)) begin bad++; $display("FAIL ext_valid[%0d] got=%b exp=%b", i, bus.wm_out_valid, (i == 31)); end
    end
    bus.pix_valid = 1'b0;
    total++; if (bus.wm_out !== ek) begin bad++; $display("FAIL ext_key got=%h exp=%h", bus.wm_out, ek); end
    @(negedge clk);
    total++; if (pulses != 1) begin bad++; $display("FAIL ext_pulses got=%0d exp=1", pulses); end
    total++; if (bus.wm_out_valid !== 1'b0) begin bad++; $display("FAIL ext_pulse_end got=%b exp=0", bus.wm_out_valid); end
    bus.mode = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    bus.mode = 1'b0;
    load_key(32'h02208880);
    bus.pix_valid = 1'b1; bus.pix_in = 8'h3C; bus.out_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_pending got=%b exp=1", bus.out_valid); end
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.pix_out !== 8'h00) begin bad++; $display("FAIL rm_pix_out got=%h exp=00", bus.pix_out); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.wm_wrap !== 1'b0) begin bad++; $display("FAIL rm_wm_wrap got=%b exp=0", bus.wm_wrap); end
    total++; if (bus.wm_out !== 32'h0) begin bad++; $display("FAIL rm_wm_out got=%h exp=0", bus.wm_out); end
    total++; if (bus.wm_out_valid !== 1'b0) begin bad++; $display("FAIL rm_wm_out_valid got=%b exp=0", bus.wm_out_valid); end
    bus.out_ready = 1'b1; bus.pix_valid = 1'b1;
    #1;
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL rm_idle_ready got=%b exp=0", bus.pix_ready); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_idle_valid got=%b exp=0", bus.out_valid); end
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.wm_load = 1'b0; bus.wm_key = '0; bus.mode = 1'b0;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.out_ready = 1'b1;
    mkey = '0; mptr = 0;
    @(negedge clk);
    test_reset;
    test_no_key;
    test_embed;
    test_backpressure;
    test_load_midstream;
`ifdef WM_EXTRACT_EN
    test_extract;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wm_embed_stream.md
WM_EMBED_STREAM -- requirements
Module: wm_embed_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter NCH, default 4, number of PIX_W-bit watermark words forming one key; key width KW = NCH*PIX_W.
REQ-003 SHALL have parameter K, default 1, watermark bits per pixel; 1 <= K <= PIX_W, and KW is a multiple of K.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port wm_load  input  1  loads key wm_key this cycle.
REQ-007 SHALL have port wm_key  input  KW  key; channel c occupies bits [c*PIX_W +: PIX_W].
REQ-008 SHALL have port mode  input  1  0 = embed, 1 = extract.
REQ-009 SHALL have port pix_in  input  PIX_W  input pixel.
REQ-010 SHALL have port pix_valid  input  1  pix_in is valid.
REQ-011 SHALL have port pix_ready  output  1  block accepts pix_in.
REQ-012 SHALL have port pix_out  output  PIX_W  output pixel, registered.
REQ-013 SHALL have port out_valid  output  1  pix_out is valid.
REQ-014 SHALL have port out_ready  input  1  sink accepts pix_out.
REQ-015 SHALL have port wm_wrap  output  1  one-cycle pulse when the bit pointer wraps.
REQ-016 SHALL have port wm_out  output  KW  extracted key, registered.
REQ-017 SHALL have port wm_out_valid  output  1  one-cycle pulse when wm_out is updated.

Function
REQ-018 SHALL implement states IDLE (no key held) and RUN (key held); IDLE->RUN on wm_load; RUN has no exit other than reset.
REQ-019 SHALL transfer an input pixel only when pix_valid && pix_ready.
REQ-020 SHALL drive pix_ready = (state==RUN || mode==1) && !wm_load && (!out_valid || out_ready).
REQ-021 SHALL register each accepted pixel into pix_out with out_valid=1 on the next cycle (latency 1 cycle).
REQ-022 SHALL hold pix_out and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL support full throughput: with out_ready held high, one pixel is accepted every cycle.
REQ-024 SHALL keep a bit pointer ptr (0..KW/K-1); in embed mode, pix_out = {pix_in[PIX_W-1:K], key[ptr*K +: K]}.
REQ-025 SHALL increment ptr per accepted pixel; at KW/K-1 it SHALL wrap to 0 and pulse wm_wrap in the same cycle pix_out updates.
REQ-026 SHALL, on wm_load, latch wm_key, reset ptr to 0 and block acceptance that cycle; a pixel already in pix_out is unaffected.
REQ-027 SHALL, in extract mode, pass pix_in to pix_out unchanged and write pix_in[K-1:0] into collect[ptr*K +: K].
REQ-028 SHALL, in extract mode, when ptr wraps, copy the completed collect word (including the current bits) to wm_out and pulse wm_out_valid for one cycle.
REQ-029 SHALL reset ptr to 0 when mode changes between accepted pixels; the partially collected word is discarded.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, set state=IDLE, ptr=0, key=0, collect=0, pix_out=0, out_valid=0, wm_wrap=0, wm_out=0 and wm_out_valid=0.
REQ-031 SHALL, on a reset asserted mid-stream, drop any pending output pixel and require a new wm_load before embedding resumes.

Configuration
REQ-032 SHALL compile extract mode only when WM_EXTRACT_EN is defined; with the macro, REQ-027 to REQ-029 apply.
REQ-033 SHALL, without WM_EXTRACT_EN, ignore mode (always embed), tie wm_out=0 and wm_out_valid=0, and omit the collect register.

Verification (defaults PIX_W=8, NCH=4, K=1)
REQ-034 SHALL cover: load wm_key=0x02208880, stream 32 pixels of 0xFF -> pix_out LSBs follow the key bits LSB-first (pixel 7 = 0xFF, pixel 0 = 0xFE); wm_wrap pulses once, on pixel 31.
REQ-035 SHALL cover: no wm_load, embed mode, pix_valid=1 -> pix_ready=0 and out_valid stays 0.
REQ-036 SHALL cover: out_ready low for 3 cycles with out_valid=1 -> pix_out stable and pix_ready=0; on release, no pixel is lost or duplicated.
REQ-037 SHALL cover: wm_load with key 0x03300CC0 asserted together with pix_valid at pixel 10 -> pixel not accepted that cycle; the next accepted pixel uses bit 0 of the new key (LSB 0).
REQ-038 SHALL cover (WM_EXTRACT_EN): extract mode, 32 pixels carrying the LSBs of 0xAA6B726A -> wm_out=0xAA6B726A and wm_out_valid pulses once; pixels pass through unchanged.
REQ-039 SHALL cover: rst_n=0 for 1 cycle while out_valid=1 mid-stream -> all outputs are 0 next cycle and state=IDLE.
